conv33_window_accum: RTL

- Downstream consumer of the 6-bit conv33 multiplier.
- Accepts one 12-bit unsigned product per handshake and sums TAPS consecutive products (one 3x3 window) into a single result.
- Presents that result over a valid/ready output; drives the tap index back upstream so weight/pixel selection stays aligned with the multiplier.

---
 rtl/conv33_window_accum.sv | 82 ++++++++
 1 files changed

// File: rtl/conv33_window_accum.sv
// conv33_window_accum
// Sums TAPS consecutive unsigned products from the conv33 multiplier into one
// window result. The result is offered downstream over valid/ready. The tap
// index goes back upstream so weight/pixel selection stays aligned.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    product handshake (in_ready has no path from in_valid)
//   in_prod              PW-bit unsigned product
//   in_last              upstream end-of-window marker, used only for framing check
//   tap_idx              index of the next product to be accepted (0..TAPS-1)
//   out_valid/out_ready  window-sum handshake
//   out_sum              OW-bit registered window sum
//   err                  sticky framing error (in_last disagrees with tap count)
module conv33_window_accum #(
  parameter int PW   = 12,
  parameter int TAPS = 9,
  parameter int OW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic [3:0]    tap_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_sum,
  output logic          err
);

  localparam logic [3:0] LAST_IDX = 4'(TAPS - 1);

  logic [OW-1:0] acc;
  logic [OW-1:0] prod_ext;
  logic [OW-1:0] sum_next;
  logic          last_tap;
  logic          accept;

  always_comb begin
    prod_ext = {{(OW-PW){1'b0}}, in_prod};
    sum_next = acc + prod_ext;
    last_tap = (tap_idx == LAST_IDX);
    // Only the window-closing tap has to wait for the previous sum to drain;
    // earlier taps never touch out_sum, so they keep flowing.
    in_ready = !(last_tap && out_valid && !out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_idx   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        if (last_tap) begin
          out_sum <= sum_next;
          tap_idx <= '0;
        end else begin
          // Tap 0 loads rather than adds, so a stale acc never leaks into a window.
          acc     <= (tap_idx == '0) ? prod_ext : sum_next;
          tap_idx <= tap_idx + 4'd1;
        end
        if (in_last != last_tap) begin
          err <= 1'b1;
        end
      end

      // A completing window keeps out_valid high even when the old sum is consumed.
      if (accept && last_tap) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
